// File: rtl/wb_dual_writeback.sv
// Dual-issue writeback stage: merges two execute results and in-order load
// returns onto the two register-file write ports, tracking queued load rds.
module wb_dual_writeback #(
    parameter int LQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        ex_valid0,
    input  logic        ex_valid1,
    input  logic        ex_is_load0,
    input  logic        ex_is_load1,
    input  logic [4:0]  ex_rd0,
    input  logic [4:0]  ex_rd1,
    input  logic [31:0] ex_data0,
    input  logic [31:0] ex_data1,
    output logic        ex_ready,
    input  logic        mem_valid,
    input  logic [31:0] mem_data,
    output logic        reg_write,
    output logic [4:0]  regd,
    output logic [31:0] write_data,
    output logic        reg_write2,
    output logic [4:0]  regd2,
    output logic [31:0] write_data2,
    output logic [31:0] pending_mask,
    output logic        lq_err
);
    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = $clog2(LQ_DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(LQ_DEPTH);

    logic [4:0]          lq_rd_reg [LQ_DEPTH];
    logic [LQ_DEPTH-1:0] lq_vld_reg;
    logic [PW-1:0]       head_reg, tail_reg;
    logic [CW-1:0]       count_reg;

    logic        reg_write_reg, reg_write2_reg, lq_err_reg;
    logic [4:0]  regd_reg, regd2_reg;
    logic [31:0] write_data_reg, write_data2_reg;

    logic        slot0_alu, slot1_alu, slot0_ld, slot1_ld;
    logic [1:0]  n_loads;
    logic [CW:0] lq_need;
    logic        lq_no_room, waw0, waw1, waw_pair;
    logic        accept, pop, lq_empty;
    logic [PW-1:0] push_idx0, push_idx1;
    logic [4:0]  head_rd;
    logic [31:0] entry_mask [LQ_DEPTH];
    logic [31:0] pend_all;

    // Each valid entry contributes a one-hot of its rd; x0 never counts as pending.
    generate
        for (genvar gi = 0; gi < LQ_DEPTH; gi++) begin : g_entry
            assign entry_mask[gi] = (lq_vld_reg[gi] && lq_rd_reg[gi] != 5'd0)
                                    ? (32'd1 << lq_rd_reg[gi]) : 32'd0;
        end
    endgenerate

    always_comb begin
        pend_all = 32'd0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            pend_all = pend_all | entry_mask[i];
        end
    end

    assign pending_mask = pend_all;

    assign slot0_alu = ex_valid0 && !ex_is_load0;
    assign slot1_alu = ex_valid1 && !ex_is_load1;
    assign slot0_ld  = ex_valid0 && ex_is_load0;
    assign slot1_ld  = ex_valid1 && ex_is_load1;
    assign n_loads   = {1'b0, slot0_ld} + {1'b0, slot1_ld};

    assign lq_need    = {1'b0, count_reg} + {{(CW - 1){1'b0}}, n_loads};
    assign lq_no_room = lq_need > DEPTH_W;
    assign waw0       = slot0_alu && ex_rd0 != 5'd0 && pend_all[ex_rd0];
    assign waw1       = slot1_alu && ex_rd1 != 5'd0 && pend_all[ex_rd1];
    // A younger ALU write must not be overtaken by the older load's later return.
    assign waw_pair   = slot1_alu && slot0_ld && ex_rd1 == ex_rd0 && ex_rd0 != 5'd0;

    assign ex_ready = !mem_valid && !lq_no_room && !waw0 && !waw1 && !waw_pair;
    assign accept   = ex_ready && (ex_valid0 || ex_valid1);
    assign lq_empty = count_reg == '0;
    assign pop      = mem_valid && !lq_empty;

    assign push_idx0 = tail_reg;
    assign push_idx1 = slot0_ld ? tail_reg + PW'(1) : tail_reg;
    assign head_rd   = lq_rd_reg[head_reg];

    always_ff @(posedge clk) begin
        if (accept && slot0_ld) lq_rd_reg[push_idx0] <= ex_rd0;
        if (accept && slot1_ld) lq_rd_reg[push_idx1] <= ex_rd1;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            lq_vld_reg <= '0;
            head_reg   <= '0;
            tail_reg   <= '0;
            count_reg  <= '0;
        end else if (pop) begin
            lq_vld_reg[head_reg] <= 1'b0;
            head_reg  <= head_reg + PW'(1);
            count_reg <= count_reg - CW'(1);
        end else if (accept) begin
            if (slot0_ld) lq_vld_reg[push_idx0] <= 1'b1;
            if (slot1_ld) lq_vld_reg[push_idx1] <= 1'b1;
            tail_reg  <= tail_reg + PW'(n_loads);
            count_reg <= count_reg + CW'(n_loads);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            reg_write_reg   <= 1'b0;
            reg_write2_reg  <= 1'b0;
            regd_reg        <= 5'd0;
            regd2_reg       <= 5'd0;
            write_data_reg  <= 32'd0;
            write_data2_reg <= 32'd0;
            lq_err_reg      <= 1'b0;
        end else begin
            reg_write_reg  <= 1'b0;
            reg_write2_reg <= 1'b0;
            if (mem_valid && lq_empty) lq_err_reg <= 1'b1;
            if (pop) begin
                reg_write_reg  <= head_rd != 5'd0;
                regd_reg       <= head_rd;
                write_data_reg <= mem_data;
            end else if (accept) begin
                // Same-rd ALU pair: only the younger slot 1 result is written.
                reg_write_reg   <= slot0_alu && ex_rd0 != 5'd0
                                   && !(slot1_alu && ex_rd1 == ex_rd0);
                regd_reg        <= ex_rd0;
                write_data_reg  <= ex_data0;
                reg_write2_reg  <= slot1_alu && ex_rd1 != 5'd0;
                regd2_reg       <= ex_rd1;
                write_data2_reg <= ex_data1;
            end
        end
    end

    assign reg_write   = reg_write_reg;
    assign regd        = regd_reg;
    assign write_data  = write_data_reg;
    assign reg_write2  = reg_write2_reg;
    assign regd2       = regd2_reg;
    assign write_data2 = write_data2_reg;
    assign lq_err      = lq_err_reg;
endmodule

// File: tb/tb_wb_dual_writeback.sv
// Randomized bench for wb_dual_writeback against a queue-based reference model.
module tb_wb_dual_writeback;
    localparam int LQ = 4;

    logic        clk, n_rst;
    logic        ex_valid0, ex_valid1, ex_is_load0, ex_is_load1;
    logic [4:0]  ex_rd0, ex_rd1;
    logic [31:0] ex_data0, ex_data1;
    logic        ex_ready, mem_valid;
    logic [31:0] mem_data;
    logic        reg_write, reg_write2, lq_err;
    logic [4:0]  regd, regd2;
    logic [31:0] write_data, write_data2, pending_mask;

    wb_dual_writeback #(.LQ_DEPTH(LQ)) dut (
        .clk(clk), .n_rst(n_rst),
        .ex_valid0(ex_valid0), .ex_valid1(ex_valid1),
        .ex_is_load0(ex_is_load0), .ex_is_load1(ex_is_load1),
        .ex_rd0(ex_rd0), .ex_rd1(ex_rd1),
        .ex_data0(ex_data0), .ex_data1(ex_data1),
        .ex_ready(ex_ready),
        .mem_valid(mem_valid), .mem_data(mem_data),
        .reg_write(reg_write), .regd(regd), .write_data(write_data),
        .reg_write2(reg_write2), .regd2(regd2), .write_data2(write_data2),
        .pending_mask(pending_mask), .lq_err(lq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int txn = 0;

    // Reference model: queued load rds in program order plus expected port values.
    logic [4:0]  lq[$];
    bit          m_err;
    bit          exp_w1, exp_w2;
    logic [4:0]  exp_rd1, exp_rd2;
    logic [31:0] exp_d1, exp_d2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (txn %0d)", name, act, want, txn);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] m = 32'd0;
        foreach (lq[i]) if (lq[i] != 5'd0) m[lq[i]] = 1'b1;
        return m;
    endfunction

    task automatic drive_idle();
        ex_valid0 = 0; ex_valid1 = 0; ex_is_load0 = 0; ex_is_load1 = 0;
        ex_rd0 = 0; ex_rd1 = 0; ex_data0 = 0; ex_data1 = 0;
        mem_valid = 0; mem_data = 0;
    endtask

    // Called just after a rising edge; returns ex_ready as seen mid-cycle.
    task automatic step(input bit v0, input bit l0, input logic [4:0] r0, input logic [31:0] d0,
                        input bit v1, input bit l1, input logic [4:0] r1, input logic [31:0] d1,
                        input bit mv, input logic [31:0] md, output bit rdy_seen);
        int cnt, nl;
        bit rdy;
        logic [31:0] pm;
        logic [4:0] h;
        ex_valid0 = v0; ex_is_load0 = l0; ex_rd0 = r0; ex_data0 = d0;
        ex_valid1 = v1; ex_is_load1 = l1; ex_rd1 = r1; ex_data1 = d1;
        mem_valid = mv; mem_data = md;
        @(negedge clk);
        cnt = lq.size();
        pm  = model_pending();
        nl  = int'(v0 && l0) + int'(v1 && l1);
        rdy = !mv && (LQ - cnt >= nl)
              && !(v0 && !l0 && r0 != 0 && pm[r0])
              && !(v1 && !l1 && r1 != 0 && pm[r1])
              && !(v1 && !l1 && v0 && l0 && r0 == r1 && r0 != 0);
        chk("ex_ready", 32'(ex_ready), 32'(rdy));
        rdy_seen = ex_ready;
        exp_w1 = 0; exp_w2 = 0;
        if (mv) begin
            if (cnt > 0) begin
                h = lq.pop_front();
                exp_w1 = (h != 0); exp_rd1 = h; exp_d1 = md;
            end else begin
                m_err = 1;
            end
        end else if (rdy && (v0 || v1)) begin
            exp_w2 = v1 && !l1 && r1 != 0; exp_rd2 = r1; exp_d2 = d1;
            exp_w1 = v0 && !l0 && r0 != 0 && !(exp_w2 && r0 == r1);
            exp_rd1 = r0; exp_d1 = d0;
            if (v0 && l0) lq.push_back(r0);
            if (v1 && l1) lq.push_back(r1);
        end
        @(posedge clk);
        #1;
        txn++;
        $display("txn %0d: v=%0b%0b ld=%0b%0b rd=%0d/%0d mv=%0b rdy=%0b wr=%0b/%0b q=%0d",
                 txn, v0, v1, l0, l1, r0, r1, mv, rdy, reg_write, reg_write2, lq.size());
        chk("reg_write", 32'(reg_write), 32'(exp_w1));
        if (exp_w1) begin
            chk("regd", 32'(regd), 32'(exp_rd1));
            chk("write_data", write_data, exp_d1);
        end
        chk("reg_write2", 32'(reg_write2), 32'(exp_w2));
        if (exp_w2) begin
            chk("regd2", 32'(regd2), 32'(exp_rd2));
            chk("write_data2", write_data2, exp_d2);
        end
        chk("lq_err", 32'(lq_err), 32'(m_err));
        chk("pending_mask", pending_mask, model_pending());
    endtask

    task automatic do_reset();
        drive_idle();
        n_rst = 0;
        @(posedge clk);
        #1;
        n_rst = 1;
        lq.delete();
        m_err = 0;
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_reg_write2", 32'(reg_write2), 32'd0);
        chk("rst_regd", 32'(regd), 32'd0);
        chk("rst_regd2", 32'(regd2), 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_write_data2", write_data2, 32'd0);
        chk("rst_pending", pending_mask, 32'd0);
        chk("rst_lq_err", 32'(lq_err), 32'd0);
    endtask

    initial begin
        bit r;
        drive_idle();
        n_rst = 0;
        m_err = 0;
        @(posedge clk);
        do_reset();

        step(1, 0, 3, 32'h11, 1, 0, 4, 32'h22, 0, 0, r);
        chk("lit_pair_w1", 32'(reg_write), 32'd1);
        chk("lit_pair_rd1", 32'(regd), 32'd3);
        chk("lit_pair_d1", write_data, 32'h11);
        chk("lit_pair_rd2", 32'(regd2), 32'd4);
        chk("lit_pair_d2", write_data2, 32'h22);

        step(1, 0, 7, 32'hA, 1, 0, 7, 32'hB, 0, 0, r);
        chk("lit_same_w1", 32'(reg_write), 32'd0);
        chk("lit_same_w2", 32'(reg_write2), 32'd1);
        chk("lit_same_d2", write_data2, 32'hB);
        step(1, 0, 0, 32'h5, 1, 0, 0, 32'h6, 0, 0, r);
        chk("lit_x0_w", 32'({reg_write, reg_write2}), 32'd0);

        step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, r);
        chk("lit_pend5", pending_mask, 32'h20);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD, r);
        chk("lit_ret_rd", 32'(regd), 32'd5);
        chk("lit_ret_d", write_data, 32'hDEAD);
        chk("lit_ret_pend", pending_mask, 32'd0);

        step(1, 1, 1, 0, 1, 1, 2, 0, 0, 0, r);
        step(1, 1, 3, 0, 1, 1, 4, 0, 0, 0, r);
        chk("lit_full_pend", pending_mask, 32'h1E);
        step(1, 1, 6, 0, 1, 1, 7, 0, 0, 0, r);
        chk("lit_full_ready", 32'(r), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'(i), r);
            chk("lit_order_rd", 32'(regd), 32'(i));
            chk("lit_order_d", write_data, 32'(i));
        end
        step(1, 1, 6, 0, 1, 1, 7, 0, 0, 0, r);
        step(1, 1, 0, 0, 1, 1, 8, 0, 0, 0, r);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100 + 32'(i), r);

        step(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, r);
        step(1, 0, 9, 32'h99, 0, 0, 0, 0, 0, 0, r);
        chk("lit_waw_ready", 32'(r), 32'd0);
        step(0, 0, 0, 0, 1, 0, 2, 32'h3, 1, 32'h9999, r);
        chk("lit_mv_ready", 32'(r), 32'd0);
        chk("lit_mv_rd", 32'(regd), 32'd9);
        step(1, 0, 9, 32'h99, 0, 0, 0, 0, 0, 0, r);
        chk("lit_waw_clear", 32'(r), 32'd1);
        step(1, 1, 12, 0, 1, 0, 12, 32'h1, 0, 0, r);
        chk("lit_pair_waw", 32'(r), 32'd0);

        for (int n = 0; n < 600; n++) begin
            bit v0, v1, l0, l1, mv;
            logic [4:0] r0, r1;
            v0 = $urandom_range(0, 3) != 0;
            v1 = $urandom_range(0, 3) != 0;
            l0 = $urandom_range(0, 2) == 0;
            l1 = $urandom_range(0, 2) == 0;
            r0 = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            r1 = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            mv = lq.size() > 0 && $urandom_range(0, 2) == 0;
            step(v0, l0, r0, $urandom, v1, l1, r1, $urandom, mv, $urandom, r);
        end

        while (lq.size() > 0) step(0, 0, 0, 0, 0, 0, 0, 0, 1, $urandom, r);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77, r);
        chk("lit_err_set", 32'(lq_err), 32'd1);
        chk("lit_err_nowrite", 32'(reg_write), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, r);
        chk("lit_err_held", 32'(lq_err), 32'd1);
        step(1, 1, 10, 0, 1, 1, 11, 0, 0, 0, r);
        do_reset();
        step(1, 0, 10, 32'h5A, 0, 0, 0, 0, 0, 0, r);
        chk("lit_rst_discard", 32'(r), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
